// File: rtl/accum_cpu_ctrl_if.sv
// Memory bus between the accumulator CPU controller (master) and a
// single-port synchronous RAM (slave).
interface accum_cpu_ctrl_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_cs, mem_we, mem_oe, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_cs, mem_we, mem_oe, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/accum_cpu_ctrl.sv
// Multi-cycle accumulator CPU control unit: fetch/decode/operand-read/execute
// sequencing against a synchronous RAM and an external combinational ALU.
module accum_cpu_ctrl #(
  parameter int          ADDR_WIDTH = 18,
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] RESET_PC   = 16'h0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             halted,
  accum_cpu_ctrl_if.master mem,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [1:0]       alu_sel,
  input  logic [15:0]      alu_out,
  output logic [15:0]      pc,
  output logic [15:0]      ir,
  output logic [15:0]      ac,
  output logic [15:0]      mbr,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_MREAD  = 4'd4,
    S_MWAIT  = 4'd5,
    S_EXEC   = 4'd6,
    S_STORE  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  localparam logic [1:0] SEL_OR  = 2'b00;
  localparam logic [1:0] SEL_ADD = 2'b01;
  localparam logic [1:0] SEL_SUB = 2'b10;
  localparam logic [1:0] SEL_AND = 2'b11;

  state_t             st;
  logic [3:0]         opcode;
  logic signed [15:0] ac_s;
  logic               skip_take;
  logic               boundary;
  logic [15:0]        pc_dec;
  logic [15:0]        fetch_pc;

  assign opcode = ir[15:12];
  assign ac_s   = ac;
  assign state  = st;

  function automatic logic [1:0] alu_sel_for(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_sel_for = SEL_ADD;
      OP_SUB:  alu_sel_for = SEL_SUB;
      OP_AND:  alu_sel_for = SEL_AND;
      default: alu_sel_for = SEL_OR;
    endcase
  endfunction

  function automatic logic is_mem_read(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND)  || (op == OP_OR);
  endfunction

  always_comb begin
    skip_take = 1'b0;
    case (ir[11:10])
      2'b00:   skip_take = (ac_s < 16'sd0);
      2'b01:   skip_take = (ac_s == 16'sd0);
      2'b10:   skip_take = (ac_s > 16'sd0);
      default: skip_take = 1'b0;
    endcase
  end

  // PC as left by DECODE; FWAIT already advanced it past the current instruction.
  always_comb begin
    pc_dec = pc;
    case (opcode)
      OP_HALT: pc_dec = pc - 16'd1;
      OP_SKIP: pc_dec = skip_take ? (pc + 16'd1) : pc;
      OP_JUMP: pc_dec = {4'h0, ir[11:0]};
      default: pc_dec = pc;
    endcase
  end

  // Instruction boundaries are the only points where run is sampled.
  always_comb begin
    boundary = 1'b0;
    case (st)
      S_IDLE, S_EXEC, S_STORE: boundary = 1'b1;
      S_DECODE: boundary = !is_mem_read(opcode) && (opcode != OP_STORE) &&
                           (opcode != OP_HALT);
      default:  boundary = 1'b0;
    endcase
  end

  assign fetch_pc = (st == S_DECODE) ? pc_dec : pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= S_IDLE;
      pc         <= RESET_PC;
      ir         <= 16'h0000;
      ac         <= 16'h0000;
      mbr        <= 16'h0000;
      halted     <= 1'b0;
      mem.mem_cs <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_oe <= 1'b0;
      alu_a      <= 16'h0000;
      alu_b      <= 16'h0000;
      alu_sel    <= SEL_OR;
    end else begin
      // Strobes are registered for the state being entered; idle by default.
      mem.mem_cs <= 1'b0;
      mem.mem_we <= 1'b0;
      mem.mem_oe <= 1'b0;
      case (st)
        S_FETCH: st <= S_FWAIT;
        S_FWAIT: begin
          ir <= 16'(mem.mem_rdata);
          pc <= pc + 16'd1;
          st <= S_DECODE;
        end
        S_DECODE: begin
          pc <= pc_dec;
          if (is_mem_read(opcode)) begin
            st           <= S_MREAD;
            mem.mem_addr <= ADDR_WIDTH'(ir[11:0]);
            mem.mem_cs   <= 1'b1;
            mem.mem_oe   <= 1'b1;
          end else if (opcode == OP_STORE) begin
            st            <= S_STORE;
            mem.mem_addr  <= ADDR_WIDTH'(ir[11:0]);
            mem.mem_cs    <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_wdata <= DATA_WIDTH'(ac);
          end else if (opcode == OP_HALT) begin
            st     <= S_HALT;
            halted <= 1'b1;
          end else if (opcode == OP_CLEAR) begin
            ac <= 16'h0000;
          end
        end
        S_MREAD: st <= S_MWAIT;
        S_MWAIT: begin
          mbr <= 16'(mem.mem_rdata);
          if (opcode != OP_LOAD) begin
            alu_a   <= ac;
            alu_b   <= 16'(mem.mem_rdata);
            alu_sel <= alu_sel_for(opcode);
          end
          st <= S_EXEC;
        end
        S_EXEC:  ac  <= (opcode == OP_LOAD) ? mbr : alu_out;
        S_STORE: mbr <= ac;
        S_HALT:  st  <= S_HALT;
        default: st  <= S_IDLE;
      endcase
      if (boundary) begin
        if (run) begin
          st           <= S_FETCH;
          mem.mem_addr <= ADDR_WIDTH'(fetch_pc);
          mem.mem_cs   <= 1'b1;
          mem.mem_oe   <= 1'b1;
        end else begin
          st <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_cpu_ctrl.sv
// Directed bench for accum_cpu_ctrl: small RAM and ALU models, hand-computed
// expected register values for each program.
module tb_accum_cpu_ctrl;
  logic        clk;
  logic        rst;
  logic        run;
  logic        halted;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic [15:0] pc, ir, ac, mbr;
  logic [3:0]  state;

  int n_checks;
  int n_fail;

  logic [15:0] img [0:1023];
  logic [15:0] mem [0:1023];
  logic        load_img;
  int          wr_cnt;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;

  accum_cpu_ctrl_if #(.ADDR_WIDTH(18), .DATA_WIDTH(16)) mem_if ();

  accum_cpu_ctrl #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .RESET_PC(16'h0100)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .halted  (halted),
    .mem     (mem_if),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .pc      (pc),
    .ir      (ir),
    .ac      (ac),
    .mbr     (mbr),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_sel)
      2'b00:   alu_out = alu_a | alu_b;
      2'b01:   alu_out = alu_a + alu_b;
      2'b10:   alu_out = alu_a - alu_b;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
      wr_cnt <= 0;
    end else if (mem_if.mem_cs && mem_if.mem_we) begin
      mem[mem_if.mem_addr[9:0]] <= mem_if.mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_if.mem_addr;
      wr_data <= mem_if.mem_wdata;
    end
    if (mem_if.mem_cs && mem_if.mem_oe) mem_if.mem_rdata <= mem[mem_if.mem_addr[9:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; load_img = 1'b1;
    @(negedge clk);
    load_img = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; run = 1'b0; load_img = 1'b0;

    // Reset state
    clear_img();
    do_reset();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_pc", 32'(pc), 32'h0100);
    check_eq("rst_ir", 32'(ir), 32'h0);
    check_eq("rst_ac", 32'(ac), 32'h0);
    check_eq("rst_mbr", 32'(mbr), 32'h0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_cs", 32'(mem_if.mem_cs), 32'd0);
    check_eq("rst_alu", {14'h0, alu_sel, alu_a}, 32'h0);

    // Load: 6 cycles after FETCH entry
    clear_img();
    img[10'h100] = 16'h1005; img[10'h101] = 16'h7000; img[10'h005] = 16'h0007;
    do_reset();
    run = 1'b1;
    step(1);
    check_eq("ld_fetch_state", 32'(state), 32'd1);
    check_eq("ld_fetch_cs", 32'({mem_if.mem_cs, mem_if.mem_oe, mem_if.mem_we}), 32'b110);
    check_eq("ld_fetch_addr", 32'(mem_if.mem_addr), 32'h100);
    step(6);
    check_eq("ld_ac", 32'(ac), 32'h0007);
    check_eq("ld_pc", 32'(pc), 32'h0101);
    check_eq("ld_state", 32'(state), 32'd1);
    wait_halt("ld");
    check_eq("ld_halt_pc", 32'(pc), 32'h0101);

    // Store
    clear_img();
    img[10'h100] = 16'h1005; img[10'h101] = 16'h2010; img[10'h102] = 16'h7000;
    img[10'h005] = 16'h0007;
    do_reset();
    run = 1'b1;
    wait_halt("st");
    check_eq("st_wr_cnt", 32'(wr_cnt), 32'd1);
    check_eq("st_wr_addr", 32'(wr_addr), 32'h010);
    check_eq("st_wr_data", 32'(wr_data), 32'h0007);
    check_eq("st_mem", 32'(mem[16]), 32'h0007);
    check_eq("st_mbr", 32'(mbr), 32'h0007);

    // Add wrap FFFF + 1
    clear_img();
    img[10'h100] = 16'h1005; img[10'h101] = 16'h3006; img[10'h102] = 16'h7000;
    img[10'h005] = 16'hFFFF; img[10'h006] = 16'h0001;
    do_reset();
    run = 1'b1;
    wait_halt("add");
    check_eq("add_ac", 32'(ac), 32'h0000);
    check_eq("add_sel", 32'(alu_sel), 32'd1);
    check_eq("add_ab", {alu_a, alu_b}, 32'hFFFF_0001);

    // Clear then sub 0 - 1
    clear_img();
    img[10'h100] = 16'hA000; img[10'h101] = 16'h4006; img[10'h102] = 16'h7000;
    img[10'h006] = 16'h0001;
    do_reset();
    run = 1'b1;
    wait_halt("sub");
    check_eq("sub_ac", 32'(ac), 32'hFFFF);
    check_eq("sub_sel", 32'(alu_sel), 32'd2);

    // AND then OR
    clear_img();
    img[10'h100] = 16'h1005; img[10'h101] = 16'h5007; img[10'h102] = 16'h6008;
    img[10'h103] = 16'h7000;
    img[10'h005] = 16'hF0F0; img[10'h007] = 16'hFF00; img[10'h008] = 16'h000F;
    do_reset();
    run = 1'b1;
    wait_halt("logic");
    check_eq("logic_ac", 32'(ac), 32'hF00F);
    check_eq("logic_sel", 32'(alu_sel), 32'd0);
    check_eq("logic_ab", {alu_a, alu_b}, 32'hF000_000F);

    // Skip on zero, taken, 3-cycle latency
    clear_img();
    img[10'h100] = 16'h8400; img[10'h101] = 16'h7000; img[10'h102] = 16'h7000;
    do_reset();
    run = 1'b1;
    step(4);
    check_eq("skz_state", 32'(state), 32'd1);
    check_eq("skz_pc", 32'(pc), 32'h0102);
    check_eq("skz_addr", 32'(mem_if.mem_addr), 32'h102);
    wait_halt("skz");
    check_eq("skz_halt_pc", 32'(pc), 32'h0102);

    // Skip tests with ac = 8000: {instr, expected halt pc}
    for (int k = 0; k < 3; k++) begin
      logic [15:0] sk_ins;
      logic [15:0] sk_pc;
      case (k)
        0:       begin sk_ins = 16'h8800; sk_pc = 16'h0102; end
        1:       begin sk_ins = 16'h8000; sk_pc = 16'h0103; end
        default: begin sk_ins = 16'h8C00; sk_pc = 16'h0102; end
      endcase
      clear_img();
      img[10'h100] = 16'h1005; img[10'h101] = sk_ins;
      img[10'h102] = 16'h7000; img[10'h103] = 16'h7000;
      img[10'h005] = 16'h8000;
      do_reset();
      run = 1'b1;
      wait_halt("skn");
      check_eq($sformatf("skn_pc_%h", sk_ins), 32'(pc), 32'(sk_pc));
    end

    // Jump
    clear_img();
    img[10'h100] = 16'h9150; img[10'h150] = 16'h7000;
    do_reset();
    run = 1'b1;
    step(4);
    check_eq("jmp_pc", 32'(pc), 32'h0150);
    check_eq("jmp_addr", 32'(mem_if.mem_addr), 32'h150);
    wait_halt("jmp");
    check_eq("jmp_halt_pc", 32'(pc), 32'h0150);

    // Halt at 100: frozen, no memory access, only rst exits
    clear_img();
    img[10'h100] = 16'h7000;
    do_reset();
    run = 1'b1;
    wait_halt("hlt");
    check_eq("hlt_pc", 32'(pc), 32'h0100);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_eq("hlt_cs", 32'(mem_if.mem_cs), 32'd0);
      check_eq("hlt_state", 32'(state), 32'd8);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("hlt_rst_state", 32'(state), 32'd0);
    check_eq("hlt_rst_halted", 32'(halted), 32'd0);

    // Reset during MWAIT of a load
    clear_img();
    img[10'h100] = 16'h1005; img[10'h005] = 16'h0007;
    do_reset();
    run = 1'b1;
    step(5);
    check_eq("abort_mwait", 32'(state), 32'd5);
    rst = 1'b1;
    step(1);
    check_eq("abort_state", 32'(state), 32'd0);
    check_eq("abort_pc", 32'(pc), 32'h0100);
    check_eq("abort_ac", 32'(ac), 32'h0);
    check_eq("abort_cs", 32'(mem_if.mem_cs), 32'd0);
    rst = 1'b0; run = 1'b0;
    step(4);
    check_eq("abort_ac_later", 32'(ac), 32'h0);
    check_eq("abort_idle", 32'(state), 32'd0);

    // run dropped right after FETCH entry: load still completes, then IDLE
    do_reset();
    run = 1'b1;
    step(1);
    run = 1'b0;
    step(6);
    check_eq("rundrop_ac", 32'(ac), 32'h0007);
    check_eq("rundrop_state", 32'(state), 32'd0);
    step(3);
    check_eq("rundrop_stay", 32'(state), 32'd0);
    check_eq("rundrop_cs", 32'(mem_if.mem_cs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/accum_cpu_ctrl.md
ACCUM_CPU_CTRL -- requirements
Module: accum_cpu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 18, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word/instruction width.
REQ-003 SHALL have parameter RESET_PC, default 'h100, program start address.
REQ-004 SHALL have ports: clk in 1, sole clock; rst in 1, reset, synchronous and active-high.
REQ-005 SHALL have: run in 1, enables instruction issue; halted out 1, high in HALT.
REQ-006 SHALL have memory ports: mem_addr out ADDR_WIDTH; mem_cs out 1; mem_we out 1; mem_oe out 1; mem_wdata out DATA_WIDTH; mem_rdata in DATA_WIDTH.
REQ-007 SHALL have ALU ports: alu_a out 16; alu_b out 16; alu_sel out 2 (00 OR, 01 ADD, 10 SUB, 11 AND); alu_out in 16, combinational result.
REQ-008 SHALL have observation ports: pc out 16; ir out 16; ac out 16; mbr out 16; state out 4.

Function
REQ-009 SHALL implement states IDLE, FETCH, FWAIT, DECODE, MREAD, MWAIT, EXEC, STORE, HALT.
REQ-010 SHALL treat memory as single-port synchronous: address sampled at posedge with cs&oe; mem_rdata valid for the whole following cycle.
REQ-011 SHALL drive mem_cs=mem_oe=0 and mem_we=0 in IDLE, DECODE, EXEC and HALT.
REQ-012 IDLE: go to FETCH when run=1, else stay.
REQ-013 FETCH: mem_addr=pc zero-extended, cs=1, oe=1, we=0; next FWAIT.
REQ-014 FWAIT: ir<=mem_rdata, pc<=pc+1 (mod 2^16); next DECODE.
REQ-015 DECODE on ir[15:12]: 1,3,4,5,6 -> MREAD; 2 -> STORE; 7 (halt) -> pc<=pc-1, HALT; 8 (skip) -> condition test; 9 (jump) -> pc<=ir[11:0] zero-extended; A (clear) -> ac<=0; all other opcodes are NOPs.
REQ-016 Skip condition on ir[11:10]: 00 ac<0 signed; 01 ac==0; 10 ac>0 signed; 11 never; pc<=pc+1 when true.
REQ-017 After DECODE for skip/jump/clear/NOP, and after EXEC/STORE, next state SHALL be FETCH if run=1, else IDLE.
REQ-018 MREAD: mem_addr=ir[11:0] zero-extended, cs=1, oe=1, we=0; next MWAIT.
REQ-019 MWAIT: mbr<=mem_rdata; next EXEC.
REQ-020 EXEC: load -> ac<=mbr; add/sub/and/or -> alu_a=ac, alu_b=mbr, alu_sel per REQ-007, ac<=alu_out.
REQ-021 alu_a/alu_b/alu_sel SHALL hold their last values outside EXEC.
REQ-022 STORE: mem_addr=ir[11:0], cs=1, we=1, oe=0, mem_wdata=ac, exactly one cycle; mbr<=ac.
REQ-023 Latency from FETCH entry: load/ALU ops 6 cycles; store 4; skip/jump/clear/NOP 3.
REQ-024 Arithmetic SHALL wrap modulo 2^16 with no flags; AC is 16 bits; pc wraps 'hFFFF->'h0000.
REQ-025 HALT: halted=1, no memory access, registers frozen, exits only via rst; run ignored.
REQ-026 run deasserting mid-instruction SHALL NOT abort it; it is sampled only at instruction boundaries.

Reset
REQ-027 rst=1 at posedge SHALL, in any state including mid-instruction, force next state IDLE, pc=RESET_PC, ir=0, ac=0, mbr=0, halted=0, mem_cs=mem_we=mem_oe=0, alu_a=alu_b=0, alu_sel=00.
REQ-028 rst SHALL take priority over all other state updates in the same cycle.

Verification
REQ-029 Load: mem[100]=1005, mem[005]=0007, run=1 -> ac=0007, pc=0101 six cycles after FETCH entry.
REQ-030 Store: ac=0007, instr 2010 -> one cycle cs=1,we=1,mem_addr=010,mem_wdata=0007; mem[010]=0007.
REQ-031 Add wrap: ac=FFFF, mem operand 0001, instr 3xxx -> alu_sel=01, ac=0000; sub 0000-0001 -> ac=FFFF.
REQ-032 Skip: ac=0000, instr 8400 at 100 -> pc=0102; ac=8000, instr 8800 -> pc=0101; instr 8000 with ac=8000 -> pc=0102.
REQ-033 Halt: instr 7000 at 100 -> halted=1, pc=0100, mem_cs=0 thereafter; rst -> IDLE, halted=0.
REQ-034 Reset in MWAIT of a load -> next cycle state=IDLE, pc=0100, ac=0, mem_cs=0; the aborted load never updates ac.
